// File: rtl/ysyx_220053_div32_pkg.sv
// ysyx_220053_div32_pkg: shared widths, FSM encodings and operand helper for the divider
package ysyx_220053_div32_pkg;
  localparam int XLEN = 32;
  localparam int DIV_CNT_W = 5;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/ysyx_220053_div_step.sv
// ysyx_220053_div_step: one restoring-division iteration (shift in dividend MSB, trial subtract)
module ysyx_220053_div_step
  import ysyx_220053_div32_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);
  logic [XLEN:0] partial;
  logic [XLEN:0] trial;
  always_comb begin
    partial = {rem, dvd_msb};
    trial   = partial - {1'b0, dvsr};
    q_bit   = partial[XLEN] || !trial[XLEN];
    rem_nxt = q_bit ? trial[XLEN-1:0] : partial[XLEN-1:0];
  end
endmodule

// File: rtl/ysyx_220053_div32.sv
// ysyx_220053_div32: iterative RV32M divider, 32 cycles per op; YSYX_220053_DIV_EARLY_OUT_EN finishes trivial cases after one
module ysyx_220053_div32
  import ysyx_220053_div32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  div_state_e state, state_nxt;
  logic [DIV_CNT_W-1:0] cnt;
  logic [XLEN-1:0] dvd, dvsr, rem, dvd_org, rem_nxt, q_raw, q_fix, r_fix;
  logic q_neg, r_neg, dz, ovf, mag, q_bit, accept, last, early;
  ysyx_220053_div_step u_step (
    .rem     (rem),
    .dvd_msb (dvd[XLEN-1]),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );
  assign in_ready  = state == DIV_IDLE;
  assign out_valid = state == DIV_DONE;
  assign accept    = in_ready && in_valid && !flush;
`ifdef YSYX_220053_DIV_EARLY_OUT_EN
  assign early = (dz || ovf || mag) && cnt == DIV_CNT_W'(XLEN-1);
`else
  assign early = 1'b0;
`endif
  assign last = cnt == '0 || early;
  // Quotient bits shift into the dividend register as its MSBs are consumed.
  always_comb begin
    q_raw = {dvd[XLEN-2:0], q_bit};
    q_fix = dz ? '1 : ovf ? {1'b1, {(XLEN-1){1'b0}}} : early && mag ? '0 : q_neg ? -q_raw : q_raw;
    r_fix = dz || (early && mag) ? dvd_org : ovf ? '0 : r_neg ? -rem_nxt : rem_nxt;
    state_nxt = flush ? DIV_IDLE
              : accept ? DIV_BUSY
              : state == DIV_BUSY && last ? DIV_DONE
              : state == DIV_DONE && out_ready ? DIV_IDLE
              : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dvd       <= '0;
      dvsr      <= '0;
      rem       <= '0;
      dvd_org   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      mag       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dvd     <= abs_if(dividend, in_signed);
        dvsr    <= abs_if(divisor, in_signed);
        rem     <= '0;
        dvd_org <= dividend;
        cnt     <= DIV_CNT_W'(XLEN-1);
        q_neg   <= in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        r_neg   <= in_signed && dividend[XLEN-1];
        dz      <= divisor == '0;
        ovf     <= in_signed && dividend == {1'b1, {(XLEN-1){1'b0}}} && divisor == '1;
        mag     <= abs_if(divisor, in_signed) > abs_if(dividend, in_signed);
      end else if (state == DIV_BUSY && !flush) begin
        dvd <= q_raw;
        rem <= rem_nxt;
        cnt <= last ? '0 : cnt - 1'b1;
        if (last) begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
      end
    end
  end
endmodule

// File: tb/tb_ysyx_220053_div32.sv
// tb_ysyx_220053_div32: directed and random divider checks against a reference RISC-V division model
module tb_ysyx_220053_div32;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_signed, flush, out_valid, out_ready;
  logic [31:0] dividend, divisor, quotient, remainder;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ysyx_220053_div32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    e.lat = 32;
`ifdef YSYX_220053_DIV_EARLY_OUT_EN
    if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || mb > ma) e.lat = 1;
`endif
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 0;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    exp_t e;
    int lat;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    in_valid = 1'b1;
    in_signed = s;
    dividend = a;
    divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_in_ready", {31'b0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_q", quotient, e.q);
      chk("hold_r", remainder, e.r);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_hs_valid", {31'b0, out_valid}, 32'd0);
  endtask
  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_signed = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    dividend = 0;
    divisor = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(-32'sd7, 32'd2, 1'b1, 0);
    run_op(32'd7, -32'sd2, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b1, 0);
    run_op(-32'sd5, 32'd0, 1'b1, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_signed = 1'b0;
    dividend = 32'd20;
    divisor = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    chk("flush_no_valid", seen, 32'd0);
    run_op(32'd9, 32'd3, 1'b0, 0);
    run_op(32'd1000, 32'd33, 1'b0, 5);
    run_op(32'd3, 32'd10, 1'b0, 0);
    run_op(-32'sd3, 32'd10, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      run_op($urandom, (i % 2 == 0) ? $urandom_range(1, 50) : $urandom, i[0], 0);
    @(negedge clk);
    in_valid = 1'b1;
    flush = 1'b1;
    dividend = 32'd8;
    divisor = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_wins_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("flush_wins_idle", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd50;
    divisor = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= int'(out_valid);
    end
    chk("mid_rst_no_valid", seen, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
